// File: rtl/pspin_cmd_dispatch_if.sv
// Bundle of the dispatcher's handshake signals: command sources, command interfaces,
// interface completions and the merged response stream.
interface pspin_cmd_dispatch_if #(
  parameter int NUM_REQ      = 8,
  parameter int NUM_INTF     = 3,
  parameter int MAX_INFLIGHT = 16,
  parameter int CMD_W        = 1024,
  parameter int RESP_W       = 523,
  parameter int INTF_IDW     = 2
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [NUM_REQ-1:0]          req_valid_i;
  logic [NUM_REQ-1:0]          req_ready_o;
  logic [NUM_REQ*INTF_IDW-1:0] req_intf_i;
  logic [NUM_REQ*CMD_W-1:0]    req_cmd_i;
  logic [NUM_INTF-1:0]         intf_valid_o;
  logic [NUM_INTF-1:0]         intf_ready_i;
  logic [NUM_INTF*CMD_W-1:0]   intf_cmd_o;
  logic [NUM_INTF-1:0]         cpl_valid_i;
  logic [NUM_INTF-1:0]         cpl_ready_o;
  logic [NUM_INTF*RESP_W-1:0]  cpl_resp_i;
  logic                        resp_valid_o;
  logic                        resp_ready_i;
  logic [RESP_W-1:0]           resp_o;
  logic [NUM_INTF*CNT_W-1:0]   inflight_o;
  logic                        err_bad_intf_o;

  modport slave (
    input  req_valid_i, req_intf_i, req_cmd_i, intf_ready_i, cpl_valid_i, cpl_resp_i, resp_ready_i,
    output req_ready_o, intf_valid_o, intf_cmd_o, cpl_ready_o, resp_valid_o, resp_o, inflight_o,
           err_bad_intf_o
  );

  modport master (
    output req_valid_i, req_intf_i, req_cmd_i, intf_ready_i, cpl_valid_i, cpl_resp_i, resp_ready_i,
    input  req_ready_o, intf_valid_o, intf_cmd_o, cpl_ready_o, resp_valid_o, resp_o, inflight_o,
           err_bad_intf_o
  );
endinterface

// File: rtl/pspin_cmd_dispatch.sv
// Round-robin command dispatcher with per-interface staging, credit counters and a
// fixed-priority completion merger into a single response register.
module pspin_cmd_dispatch_chk #(
  parameter int NUM_INTF     = 3,
  parameter int CNT_W        = 5,
  parameter int MAX_INFLIGHT = 16
) (
  input logic                               clk_i,
  input logic                               rst_i,
  input logic [NUM_INTF-1:0]                cpl_hs,
  input logic [NUM_INTF-1:0][CNT_W-1:0]     cnt
);
  for (genvar i = 0; i < NUM_INTF; i++) begin : g_chk
    a_cpl_at_zero: assert property (@(posedge clk_i) disable iff (rst_i)
      !(cpl_hs[i] && (cnt[i] == CNT_W'(0))));
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      cnt[i] <= CNT_W'(MAX_INFLIGHT));
  end
endmodule

module pspin_cmd_dispatch #(
  parameter int NUM_REQ      = 8,
  parameter int NUM_INTF     = 3,
  parameter int MAX_INFLIGHT = 16,
  parameter int CMD_W        = 1024,
  parameter int RESP_W       = 523,
  parameter int INTF_IDW     = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  pspin_cmd_dispatch_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [PTR_W-1:0]                     ptr_r;
  logic [NUM_INTF-1:0]                  stage_valid_r;
  logic [NUM_INTF-1:0][CMD_W-1:0]       stage_cmd_r;
  logic [NUM_INTF-1:0][CNT_W-1:0]       cnt_r;
  logic                                 resp_valid_r;
  logic [RESP_W-1:0]                    resp_r;
  logic                                 err_r;

  logic [NUM_INTF-1:0]                  stage_free_s;
  logic [NUM_INTF-1:0]                  credit_ok_s;
  logic [NUM_REQ-1:0][NUM_INTF-1:0]     tgt_oh_s;
  logic [NUM_REQ-1:0]                   bad_s;
  logic [NUM_REQ-1:0]                   elig_s;
  logic [NUM_REQ-1:0]                   gnt_oh_s;
  logic                                 gnt_any_s;
  logic                                 gnt_bad_s;
  logic [NUM_INTF-1:0]                  gnt_tgt_s;
  logic [CMD_W-1:0]                     gnt_cmd_s;
  logic [PTR_W-1:0]                     ptr_nxt_s;
  logic [NUM_INTF-1:0]                  issue_s;
  logic [NUM_INTF-1:0]                  cpl_win_s;
  logic [NUM_INTF-1:0]                  cpl_hs_s;
  logic [RESP_W-1:0]                    cpl_data_s;
  logic                                 resp_free_s;

  // Source eligibility; an intf_id with no matching interface is always taken so it can be dropped.
  always_comb begin
    stage_free_s = ~stage_valid_r | bus.intf_ready_i;
    tgt_oh_s     = '0;
    bad_s        = '0;
    elig_s       = '0;
    for (int i = 0; i < NUM_INTF; i++) begin
      credit_ok_s[i] = (cnt_r[i] < CNT_MAX);
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      for (int i = 0; i < NUM_INTF; i++) begin
        tgt_oh_s[r][i] = (bus.req_intf_i[r*INTF_IDW +: INTF_IDW] == INTF_IDW'(i));
      end
      bad_s[r]  = ~|tgt_oh_s[r];
      elig_s[r] = bus.req_valid_i[r] & (bad_s[r] | (|(tgt_oh_s[r] & stage_free_s & credit_ok_s)));
    end
  end

  // Round-robin scan starting at ptr_r, then AND-OR select of the grantee's fields.
  always_comb begin
    logic seen;
    seen      = 1'b0;
    gnt_oh_s  = '0;
    gnt_bad_s = 1'b0;
    gnt_tgt_s = '0;
    gnt_cmd_s = '0;
    ptr_nxt_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if ((((int'(ptr_r) + k) % NUM_REQ) == r) && elig_s[r] && !seen) begin
          gnt_oh_s[r] = 1'b1;
          seen        = 1'b1;
        end else begin
          gnt_oh_s[r] = gnt_oh_s[r];
        end
      end
    end
    gnt_any_s = |gnt_oh_s;
    for (int r = 0; r < NUM_REQ; r++) begin
      gnt_bad_s = gnt_bad_s | (gnt_oh_s[r] & bad_s[r]);
      gnt_tgt_s = gnt_tgt_s | ({NUM_INTF{gnt_oh_s[r]}} & tgt_oh_s[r]);
      gnt_cmd_s = gnt_cmd_s | ({CMD_W{gnt_oh_s[r]}} & bus.req_cmd_i[r*CMD_W +: CMD_W]);
      ptr_nxt_s = ptr_nxt_s | ({PTR_W{gnt_oh_s[r]}} & PTR_W'((r + 1) % NUM_REQ));
    end
    issue_s = {NUM_INTF{gnt_any_s & ~gnt_bad_s}} & gnt_tgt_s;
  end

  // Completion merge: lowest-index valid interface wins when the response slot frees up.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    cpl_data_s = '0;
    for (int i = 0; i < NUM_INTF; i++) begin
      cpl_win_s[i] = bus.cpl_valid_i[i] & ~seen;
      seen         = seen | bus.cpl_valid_i[i];
    end
    resp_free_s = ~resp_valid_r | bus.resp_ready_i;
    cpl_hs_s    = cpl_win_s & {NUM_INTF{resp_free_s & ~rst_i}};
    for (int i = 0; i < NUM_INTF; i++) begin
      cpl_data_s = cpl_data_s | ({RESP_W{cpl_hs_s[i]}} & bus.cpl_resp_i[i*RESP_W +: RESP_W]);
    end
  end

  // Pointer, interface stages, credit counters, response register and error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_r         <= '0;
      stage_valid_r <= '0;
      stage_cmd_r   <= '0;
      cnt_r         <= '0;
      resp_valid_r  <= 1'b0;
      resp_r        <= '0;
      err_r         <= 1'b0;
    end else begin
      if (gnt_any_s) begin
        ptr_r <= ptr_nxt_s;
      end
      err_r <= gnt_any_s & gnt_bad_s;
      for (int i = 0; i < NUM_INTF; i++) begin
        if (issue_s[i]) begin
          stage_valid_r[i] <= 1'b1;
          stage_cmd_r[i]   <= gnt_cmd_s;
        end else if (bus.intf_ready_i[i]) begin
          stage_valid_r[i] <= 1'b0;
        end
        if (issue_s[i] && !cpl_hs_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else if (cpl_hs_s[i] && !issue_s[i] && (cnt_r[i] != CNT_W'(0))) begin
          cnt_r[i] <= cnt_r[i] - CNT_W'(1);
        end
      end
      if (|cpl_hs_s) begin
        resp_valid_r <= 1'b1;
        resp_r       <= cpl_data_s;
      end else if (bus.resp_ready_i) begin
        resp_valid_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready_o    = gnt_oh_s & {NUM_REQ{~rst_i}};
  assign bus.cpl_ready_o    = cpl_hs_s;
  assign bus.intf_valid_o   = stage_valid_r;
  assign bus.intf_cmd_o     = stage_cmd_r;
  assign bus.inflight_o     = cnt_r;
  assign bus.resp_valid_o   = resp_valid_r;
  assign bus.resp_o         = resp_r;
  assign bus.err_bad_intf_o = err_r;

  pspin_cmd_dispatch_chk #(
    .NUM_INTF     (NUM_INTF),
    .CNT_W        (CNT_W),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_chk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cpl_hs (cpl_hs_s),
    .cnt    (cnt_r)
  );
endmodule

// File: tb/tb_pspin_cmd_dispatch.sv
// Randomized bench for pspin_cmd_dispatch: a transaction-level reference model predicts grants,
// staged commands, credits and merged responses; a negedge monitor compares against the DUT.
module tb_pspin_cmd_dispatch;
  localparam int NR   = 4;
  localparam int NI   = 3;
  localparam int MAXF = 2;
  localparam int CW   = 32;
  localparam int RW   = 24;
  localparam int IW   = 2;
  localparam int CNTW = $clog2(MAXF + 1);

  logic clk;
  logic rst;
  int   phase;
  int   n_checks;
  int   n_fail;

  pspin_cmd_dispatch_if #(.NUM_REQ(NR), .NUM_INTF(NI), .MAX_INFLIGHT(MAXF),
                          .CMD_W(CW), .RESP_W(RW), .INTF_IDW(IW)) bus ();

  pspin_cmd_dispatch #(.NUM_REQ(NR), .NUM_INTF(NI), .MAX_INFLIGHT(MAXF),
                       .CMD_W(CW), .RESP_W(RW), .INTF_IDW(IW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: outstanding work expressed as queues and plain counts.
  logic [CW-1:0] stage_q[NI][$];
  logic [RW-1:0] resp_q[$];
  int            cnt[NI];
  int            rr_next;
  bit            err_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_elig(input int s);
    int t;
    t = int'(bus.req_intf_i[s*IW +: IW]);
    if (!bus.req_valid_i[s]) return 1'b0;
    if (t >= NI) return 1'b1;
    return ((stage_q[t].size() == 0) || bus.intf_ready_i[t]) && (cnt[t] < MAXF);
  endfunction

  // Monitor/scoreboard.
  initial begin : monitor
    int g, w, s, t;
    bit rfree;
    logic [NR-1:0] exp_rdy;
    logic [NI-1:0] exp_cpl;
    rr_next = 0;
    err_exp = 1'b0;
    for (int i = 0; i < NI; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'(0));
        chk("rst_cpl_ready", 64'(bus.cpl_ready_o), 64'(0));
        chk("rst_intf_valid", 64'(bus.intf_valid_o), 64'(0));
        chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'(0));
        chk("rst_inflight", 64'(bus.inflight_o), 64'(0));
        chk("rst_err", 64'(bus.err_bad_intf_o), 64'(0));
        for (int i = 0; i < NI; i++) begin
          stage_q[i].delete();
          cnt[i] = 0;
        end
        resp_q.delete();
        rr_next = 0;
        err_exp = 1'b0;
      end else begin
        g = -1;
        for (int k = 0; k < NR; k++) begin
          s = (rr_next + k) % NR;
          if (g < 0 && model_elig(s)) g = s;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
        for (int i = 0; i < NI; i++) begin
          chk("intf_valid", 64'(bus.intf_valid_o[i]), 64'(stage_q[i].size() != 0));
          if (stage_q[i].size() != 0)
            chk("intf_cmd", 64'(bus.intf_cmd_o[i*CW +: CW]), 64'(stage_q[i][0]));
          chk("inflight", 64'(bus.inflight_o[i*CNTW +: CNTW]), 64'(cnt[i]));
        end
        w = -1;
        for (int i = 0; i < NI; i++) if (w < 0 && bus.cpl_valid_i[i]) w = i;
        rfree   = (resp_q.size() == 0) || bus.resp_ready_i;
        exp_cpl = '0;
        if (w >= 0 && rfree) exp_cpl[w] = 1'b1;
        chk("cpl_ready", 64'(bus.cpl_ready_o), 64'(exp_cpl));
        chk("resp_valid", 64'(bus.resp_valid_o), 64'(resp_q.size() != 0));
        if (resp_q.size() != 0) chk("resp_data", 64'(bus.resp_o), 64'(resp_q[0]));
        chk("err_bad_intf", 64'(bus.err_bad_intf_o), 64'(err_exp));

        // Advance the model to what the next edge commits.
        for (int i = 0; i < NI; i++)
          if (stage_q[i].size() != 0 && bus.intf_ready_i[i]) void'(stage_q[i].pop_front());
        if (resp_q.size() != 0 && bus.resp_ready_i) void'(resp_q.pop_front());
        err_exp = 1'b0;
        if (g >= 0) begin
          t = int'(bus.req_intf_i[g*IW +: IW]);
          if (t >= NI) err_exp = 1'b1;
          else begin
            stage_q[t].push_back(bus.req_cmd_i[g*CW +: CW]);
            cnt[t]++;
          end
          rr_next = (g + 1) % NR;
        end
        if (exp_cpl != '0) begin
          resp_q.push_back(bus.cpl_resp_i[w*RW +: RW]);
          if (cnt[w] > 0) cnt[w]--;
        end
      end
    end
  end

  // Stimulus: sources, interface sinks, completion returners and response sink.
  initial begin : drive
    logic [NR-1:0] req_hs;
    logic [NI-1:0] intf_hs, cpl_hs;
    int pend[NI];
    int p_req, p_rdy, p_cpl, p_rsp, r;
    bus.req_valid_i  = '0;
    bus.req_intf_i   = '0;
    bus.req_cmd_i    = '0;
    bus.intf_ready_i = '0;
    bus.cpl_valid_i  = '0;
    bus.cpl_resp_i   = '0;
    bus.resp_ready_i = 1'b0;
    for (int i = 0; i < NI; i++) pend[i] = 0;
    forever begin
      @(negedge clk);
      req_hs  = bus.req_valid_i & bus.req_ready_o;
      intf_hs = bus.intf_valid_o & bus.intf_ready_i;
      cpl_hs  = bus.cpl_valid_i & bus.cpl_ready_o;
      @(posedge clk);
      #2;
      case (phase)
        0:       begin p_req = 100; p_rdy = 100; p_cpl = 100; p_rsp = 100; end
        1:       begin p_req = 70;  p_rdy = 60;  p_cpl = 50;  p_rsp = 70;  end
        default: begin p_req = 80;  p_rdy = 80;  p_cpl = 60;  p_rsp = 15;  end
      endcase
      if (rst) begin
        bus.req_valid_i  = '0;
        bus.intf_ready_i = '0;
        bus.cpl_valid_i  = '0;
        bus.resp_ready_i = 1'b0;
        for (int i = 0; i < NI; i++) pend[i] = 0;
      end else begin
        for (int s = 0; s < NR; s++) begin
          if (!bus.req_valid_i[s] || req_hs[s]) begin
            bus.req_valid_i[s] = ($urandom_range(0, 99) < p_req);
            r = $urandom_range(0, 15);
            if (phase == 0) bus.req_intf_i[s*IW +: IW] = IW'(0);
            else if (r < 2) bus.req_intf_i[s*IW +: IW] = IW'(3);
            else bus.req_intf_i[s*IW +: IW] = IW'(r % NI);
            bus.req_cmd_i[s*CW +: CW] = $urandom;
          end
        end
        for (int i = 0; i < NI; i++) begin
          bus.intf_ready_i[i] = ($urandom_range(0, 99) < p_rdy);
          pend[i] += int'(intf_hs[i]);
          if (cpl_hs[i]) begin
            pend[i]--;
            bus.cpl_valid_i[i] = 1'b0;
          end
          if (!bus.cpl_valid_i[i] && pend[i] > 0 && $urandom_range(0, 99) < p_cpl) begin
            bus.cpl_valid_i[i] = 1'b1;
            bus.cpl_resp_i[i*RW +: RW] = RW'($urandom);
          end
        end
        bus.resp_ready_i = ($urandom_range(0, 99) < p_rsp);
      end
    end
  end

  initial begin : main
    n_checks = 0;
    n_fail   = 0;
    phase    = 0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (300) @(posedge clk);
    #1 phase = 1;
    repeat (1500) @(posedge clk);
    #1 phase = 2;
    repeat (800) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    phase = 1;
    repeat (600) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
